// File: rtl/cpu_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_param : parametrised multicycle accumulator CPU (A/B, C/Z, UART I/O)  |
// | Optional macro CPU_JUMP_EN enables JMP/JZ/JC; otherwise they are 2-byte   |
// | NOPs. Revision: 1.0                                                       |
// +--------------------------------------------------------------------------+
module cpu_param #(
    parameter int DW      = 8,
    parameter int AW      = 9,
    parameter int RD_WAIT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] startaddr,
    input  logic [DW-1:0] dread,
    output logic [AW-1:0] c_raddr,
    output logic [AW-1:0] c_waddr,
    output logic [DW-1:0] dwrite,
    output logic          write_en,
    output logic [7:0]    tx_byte,
    output logic          transmit,
    input  logic          is_transmitting,
    input  logic          received,
    input  logic [7:0]    rx_byte,
    output logic          led,
    output logic          halted
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_WAIT1   = 4'd2,
        S_OPLOAD  = 4'd3,
        S_DECODE  = 4'd4,
        S_WAIT2   = 4'd5,
        S_OPLOAD2 = 4'd6,
        S_DECODE2 = 4'd7,
        S_WAIT3   = 4'd8,
        S_MEMLOAD = 4'd9,
        S_OUT     = 4'd10,
        S_IN      = 4'd11
    } state_t;

    localparam logic [2:0]  WAIT_LAST1  = 3'(RD_WAIT - 1);
    localparam logic [2:0]  WAIT_LAST23 = 3'(RD_WAIT);
    localparam logic [DW:0] ALU_ONE     = (DW+1)'(1);

    state_t        state, state_n;
    logic [2:0]    wcnt;
    logic [AW-1:0] pc;
    logic [DW-1:0] a, b, operand;
    logic [7:0]    opcode;
    logic          cflag, zflag;
    logic [DW:0]   alu_sum;
    logic [AW-1:0] opaddr;
    logic          wait_st, wait_done;

    assign opaddr    = AW'(operand);
    assign wait_st   = (state == S_WAIT1) || (state == S_WAIT2) || (state == S_WAIT3);
    // Operand and data-memory reads hold one cycle longer than the opcode read.
    assign wait_done = (state == S_WAIT1) ? (wcnt == WAIT_LAST1) : (wcnt == WAIT_LAST23);

    always_comb begin
        alu_sum = {1'b0, a} + {1'b0, b};
        if (opcode == 8'h05) begin
            alu_sum = {1'b0, a} + {1'b0, ~b} + ALU_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            wcnt  <= 3'd0;
        end else begin
            state <= state_n;
            wcnt  <= (wait_st && !wait_done) ? wcnt + 3'd1 : 3'd0;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:    if (start) state_n = S_FETCH;
            S_FETCH:   state_n = S_WAIT1;
            S_WAIT1:   if (wait_done) state_n = S_OPLOAD;
            S_OPLOAD:  state_n = S_DECODE;
            S_DECODE: begin
                if (opcode[7]) begin
                    state_n = S_WAIT2;
                end else begin
                    case (opcode)
                        8'h00:   state_n = S_IDLE;
                        8'h01:   state_n = S_OUT;
                        8'h02:   state_n = S_IN;
                        default: state_n = S_FETCH;
                    endcase
                end
            end
            S_WAIT2:   if (wait_done) state_n = S_OPLOAD2;
            S_OPLOAD2: state_n = S_DECODE2;
            S_DECODE2: state_n = (opcode == 8'h84) ? S_WAIT3 : S_FETCH;
            S_WAIT3:   if (wait_done) state_n = S_MEMLOAD;
            S_MEMLOAD: state_n = S_FETCH;
            S_OUT:     if (!is_transmitting) state_n = S_FETCH;
            S_IN:      if (received) state_n = S_FETCH;
            default:   state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= '0;
            a        <= '0;
            b        <= '0;
            operand  <= '0;
            opcode   <= 8'h00;
            cflag    <= 1'b0;
            zflag    <= 1'b0;
            c_raddr  <= '0;
            c_waddr  <= '0;
            dwrite   <= '0;
            write_en <= 1'b0;
            tx_byte  <= 8'h00;
            transmit <= 1'b0;
            led      <= 1'b0;
            halted   <= 1'b0;
        end else begin
            write_en <= 1'b0;
            transmit <= 1'b0;
            led      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pc     <= startaddr;
                        led    <= 1'b1;
                        halted <= 1'b0;
                    end
                end
                S_FETCH: c_raddr <= pc;
                S_OPLOAD: begin
                    opcode <= dread[7:0];
                    pc     <= pc + AW'(1);
                end
                S_DECODE: begin
                    if (opcode[7]) begin
                        c_raddr <= pc;
                    end else begin
                        case (opcode)
                            8'h00: halted <= 1'b1;
                            8'h04, 8'h05: begin
                                {cflag, a} <= alu_sum;
                                zflag      <= (alu_sum[DW-1:0] == '0);
                            end
                            8'h06: b <= a;
                            default: ;
                        endcase
                    end
                end
                S_OPLOAD2: begin
                    operand <= dread;
                    pc      <= pc + AW'(1);
                end
                S_DECODE2: begin
                    case (opcode)
                        8'h80: a <= operand;
                        8'h81: b <= operand;
                        8'h84: c_raddr <= opaddr;
                        8'h88: begin
                            c_waddr  <= opaddr;
                            dwrite   <= a;
                            write_en <= 1'b1;
                        end
`ifdef CPU_JUMP_EN
                        8'h90: pc <= opaddr;
                        8'h91: if (zflag) pc <= opaddr;
                        8'h92: if (cflag) pc <= opaddr;
`endif
                        default: ;
                    endcase
                end
                S_MEMLOAD: a <= dread;
                S_OUT: begin
                    if (!is_transmitting) begin
                        tx_byte  <= a[7:0];
                        transmit <= 1'b1;
                    end
                end
                S_IN: if (received) a <= DW'(rx_byte);
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cpu_param : directed programs on two cpu_param builds (8/9/1, 16/16/3) |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_cpu_param;

`ifdef CPU_JUMP_EN
    localparam bit JEN = 1'b1;
`else
    localparam bit JEN = 1'b0;
`endif
    localparam int NC = 400;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic [8:0]  sa0 = '0;
    logic [15:0] sa1 = '0;
    logic        is_tx = 1'b0, received = 1'b0;
    logic [7:0]  rx_byte = 8'h00;

    logic [7:0]  dread0, dwrite0, txb0, txb1;
    logic [8:0]  raddr0, waddr0;
    logic [15:0] dread1, dwrite1, raddr1, waddr1;
    logic        we0, tx0, led0, halt0, we1, tx1, led1, halt1;

    cpu_param u0 (
        .clk(clk), .rst(rst), .start(start0), .startaddr(sa0), .dread(dread0),
        .c_raddr(raddr0), .c_waddr(waddr0), .dwrite(dwrite0), .write_en(we0),
        .tx_byte(txb0), .transmit(tx0), .is_transmitting(is_tx),
        .received(received), .rx_byte(rx_byte), .led(led0), .halted(halt0)
    );

    cpu_param #(.DW(16), .AW(16), .RD_WAIT(3)) u1 (
        .clk(clk), .rst(rst), .start(start1), .startaddr(sa1), .dread(dread1),
        .c_raddr(raddr1), .c_waddr(waddr1), .dwrite(dwrite1), .write_en(we1),
        .tx_byte(txb1), .transmit(tx1), .is_transmitting(is_tx),
        .received(received), .rx_byte(rx_byte), .led(led1), .halted(halt1)
    );

    // Write-first block RAMs with a bench-side load port.
    logic [7:0]  ram0 [0:511];
    logic [15:0] ram1 [0:65535];
    logic        ld_en = 1'b0, ld_k = 1'b0;
    logic [15:0] ld_addr = '0, ld_data = '0;

    always @(posedge clk) begin
        if (ld_en && !ld_k) ram0[ld_addr[8:0]] <= ld_data[7:0];
        else if (we0) ram0[waddr0] <= dwrite0;
        dread0 <= (we0 && waddr0 == raddr0) ? dwrite0 : ram0[raddr0];
    end

    always @(posedge clk) begin
        if (ld_en && ld_k) ram1[ld_addr] <= ld_data;
        else if (we1) ram1[waddr1] <= dwrite1;
        dread1 <= (we1 && waddr1 == raddr1) ? dwrite1 : ram1[raddr1];
    end

    int vec = 0, bad = 0, cyc = 0, cur = 0;
    bit active = 1'b0;
    logic [15:0] mm [2][0:65535];
    bit ex_we [NC];
    bit ex_tx [NC];
    int ex_wa [NC], ex_wd [NC], ex_txb [NC];
    int ex_halt;
    int itx_until = 0, rx_cycle = -1, rx_val = 0;
    int obs_txb, obs_tx_cyc, obs_wa, obs_wd, obs_we_cyc, obs_halt_cyc;

    task automatic chk(input string nm, input int act, input int exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic poke(input int k, input int addr, input int val);
        mm[k][addr] = 16'(val);
        ld_en = 1'b1; ld_k = k[0]; ld_addr = 16'(addr); ld_data = 16'(val);
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic load(input int k, input int base, input int q[$]);
        foreach (q[i]) poke(k, base + i, q[i]);
    endtask

    // Instruction-level model: executes the program and stamps each visible
    // event at the cycle implied by the per-instruction cycle formulas.
    task automatic model_run(input int k, input int saddr);
        int dw, aw, w, dm, am, pc, a, b, cf, zf, t, tn, op, opnd, sum, c;
        bit done;
        dw = k ? 16 : 8; aw = k ? 16 : 9; w = k ? 3 : 1;
        dm = (1 << dw) - 1; am = (1 << aw) - 1;
        for (int i = 0; i < NC; i++) begin
            ex_we[i] = 0; ex_tx[i] = 0; ex_wa[i] = 0; ex_wd[i] = 0; ex_txb[i] = 0;
        end
        a = 0; b = 0; cf = 0; zf = 0; pc = saddr; t = 1; done = 0; ex_halt = NC - 1;
        for (int n = 0; n < 100 && !done; n++) begin
            op = int'(mm[k][pc]) & 'hFF;
            pc = (pc + 1) & am;
            if (op < 'h80) begin
                tn = t + 3 + w;
                case (op)
                    'h00: begin ex_halt = t + w + 3; done = 1; end
                    'h01: begin
                        c = t + w + 3;
                        while (c <= itx_until) c++;
                        if (c + 1 < NC) begin ex_tx[c+1] = 1; ex_txb[c+1] = a & 'hFF; end
                        tn = c + 1;
                    end
                    'h02: begin a = rx_val & 'hFF; tn = rx_cycle + 1; end
                    'h04, 'h05: begin
                        sum = (op == 'h04) ? a + b : a + ((~b) & dm) + 1;
                        cf = (sum >> dw) & 1; a = sum & dm; zf = (a == 0);
                    end
                    'h06: b = a;
                    default: ;
                endcase
                t = tn;
            end else begin
                opnd = int'(mm[k][pc]) & dm;
                pc = (pc + 1) & am;
                tn = t + 6 + 2 * w;
                case (op)
                    'h80: a = opnd;
                    'h81: b = opnd;
                    'h84: begin a = int'(mm[k][opnd]) & dm; tn = t + 8 + 3 * w; end
                    'h88: begin
                        mm[k][opnd] = 16'(a);
                        if (t + 2 * w + 6 < NC) begin
                            ex_we[t+2*w+6] = 1; ex_wa[t+2*w+6] = opnd; ex_wd[t+2*w+6] = a;
                        end
                    end
                    'h90: if (JEN) pc = opnd;
                    'h91: if (JEN && zf != 0) pc = opnd;
                    'h92: if (JEN && cf != 0) pc = opnd;
                    default: ;
                endcase
                t = tn;
            end
        end
    endtask

    always @(negedge clk) begin
        if (active && cyc < NC) begin
            int wa, wd, tb;
            bit we, tx, ld, hl;
            we = cur ? we1 : we0;     tx = cur ? tx1 : tx0;
            ld = cur ? led1 : led0;   hl = cur ? halt1 : halt0;
            wa = cur ? int'(waddr1) : int'(waddr0);
            wd = cur ? int'(dwrite1) : int'(dwrite0);
            tb = cur ? int'(txb1) : int'(txb0);
            chk("write_en", int'(we), int'(ex_we[cyc]));
            if (ex_we[cyc]) begin
                chk("c_waddr", wa, ex_wa[cyc]);
                chk("dwrite", wd, ex_wd[cyc]);
            end
            chk("transmit", int'(tx), int'(ex_tx[cyc]));
            if (ex_tx[cyc]) chk("tx_byte", tb, ex_txb[cyc]);
            chk("led", int'(ld), int'(cyc == 1));
            chk("halted", int'(hl), int'(cyc >= ex_halt));
            if (tx) begin obs_txb = tb; obs_tx_cyc = cyc; end
            if (we) begin obs_wa = wa; obs_wd = wd; obs_we_cyc = cyc; end
            if (hl && obs_halt_cyc < 0) obs_halt_cyc = cyc;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic pulse_start(input int k, input int saddr);
        if (k == 0) begin sa0 = 9'(saddr); start0 = 1'b1; end
        else begin sa1 = 16'(saddr); start1 = 1'b1; end
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
    endtask

    task automatic run(input int k, input int saddr);
        model_run(k, saddr);
        rx_byte = 8'(rx_val);
        obs_txb = -1; obs_tx_cyc = -1; obs_wa = -1; obs_wd = -1; obs_we_cyc = -1; obs_halt_cyc = -1;
        cur = k;
        pulse_start(k, saddr);
        cyc = 1; active = 1'b1;
        while (cyc <= ex_halt + 1 && cyc < NC) begin
            is_tx = (cyc <= itx_until);
            received = (cyc == rx_cycle);
            @(posedge clk); #1;
            cyc++;
        end
        active = 1'b0; is_tx = 1'b0; received = 1'b0;
        itx_until = 0; rx_cycle = -1; rx_val = 0;
    endtask

    task automatic chk_quiet(input string nm);
        @(negedge clk);
        chk({nm, "_raddr"}, int'(raddr0), 0);
        chk({nm, "_waddr"}, int'(waddr0), 0);
        chk({nm, "_dwrite"}, int'(dwrite0), 0);
        chk({nm, "_we"}, int'(we0), 0);
        chk({nm, "_txb"}, int'(txb0), 0);
        chk({nm, "_tx"}, int'(tx0), 0);
        chk({nm, "_led"}, int'(led0), 0);
        chk({nm, "_halted"}, int'(halt0), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        do_reset();
        chk_quiet("rst0");
        @(negedge clk);
        chk("rst1_raddr", int'(raddr1), 0);
        chk("rst1_out", int'({we1, tx1, led1, halt1, txb1, dwrite1, waddr1}), 0);
        @(posedge clk); #1;

        // ADD with flags
        load(0, 0, '{'h80, 'h05, 'h81, 'h03, 'h04, 'h01, 'h00});
        run(0, 0);
        chk("add_tx", obs_txb, 'h08);
        chk("add_halt_cycle", obs_halt_cyc, 30);

        // Carry/zero then JC
        do_reset();
        load(0, 0, '{'h80, 'hFF, 'h81, 'h01, 'h04, 'h92, 'h20, 'h01, 'h00});
        load(0, 'h20, '{'h80, 'hAA, 'h01, 'h00});
        run(0, 0);
        chk("jc_tx", obs_txb, JEN ? 'hAA : 'h00);

        // Memory round trip, RD_WAIT = 1 then RD_WAIT = 3
        do_reset();
        load(0, 0, '{'h80, 'h5A, 'h88, 'h40, 'h80, 'h00, 'h84, 'h40, 'h01, 'h00});
        run(0, 0);
        chk("mem_waddr", obs_wa, 'h40);
        chk("mem_we_cycle", obs_we_cyc, 17);
        chk("mem_tx", obs_txb, 'h5A);
        chk("mem_halt_cycle", obs_halt_cyc, 45);
        load(1, 0, '{'h80, 'h5A, 'h88, 'h40, 'h80, 'h00, 'h84, 'h40, 'h01, 'h00});
        run(1, 0);
        chk("mem3_we_cycle", obs_we_cyc, 25);
        chk("mem3_tx", obs_txb, 'h5A);
        chk("mem3_halt_cycle", obs_halt_cyc, 67);

        // TX busy stall, with a stray RX pulse that must be ignored
        do_reset();
        load(0, 0, '{'h80, 'h11, 'h01, 'h00});
        itx_until = 50; rx_cycle = 5; rx_val = 'h77;
        run(0, 0);
        chk("stall_tx_cycle", obs_tx_cyc, 52);
        chk("stall_tx", obs_txb, 'h11);

        // IN waiting for a late RX pulse
        do_reset();
        load(0, 0, '{'h02, 'h01, 'h00});
        rx_cycle = 30; rx_val = 'h33;
        run(0, 0);
        chk("in_tx", obs_txb, 'h33);
        chk("in_halt_cycle", obs_halt_cyc, 40);

        // Reset during the IN stall
        do_reset();
        load(0, 0, '{'h02, 'h00});
        pulse_start(0, 0);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        received = 1'b1; rx_byte = 8'h44;
        @(posedge clk); #1 received = 1'b0;
        chk_quiet("rstin");
        repeat (5) @(posedge clk);
        #1 chk_quiet("rstin_idle");

        // Reset on the STA decode cycle
        do_reset();
        load(0, 0, '{'h80, 'h5A, 'h88, 'h40, 'h00});
        poke(0, 'h40, 'h11);
        pulse_start(0, 0);
        repeat (15) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk_quiet("rststa");
        repeat (3) @(posedge clk);
        #1 chk("rststa_ram", int'(ram0[9'h040]), 'h11);
        chk_quiet("rststa_idle");

        // Wide build: address wrap and SUB borrow
        do_reset();
        poke(1, 'hFFFF, 'hAB03);
        load(1, 0, '{'h81, 'h01, 'h05, 'h88, 'h50, 'h92, 'h30, 'h91, 'h30, 'h01, 'h00});
        load(1, 'h30, '{'h80, 'hEE, 'h01, 'h00});
        run(1, 'hFFFF);
        chk("wide_waddr", obs_wa, 'h50);
        chk("wide_sub", obs_wd, 'hFFFF);
        chk("wide_tx", obs_txb, 'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
`default_nettype wire
